// File: rtl/mc_datapath_hs.sv
// mc_datapath_hs: multicycle RV32I/E datapath with a req/ready bus sequencer; MULDIV_EN adds a shift-add multiplier
module mc_datapath_hs #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 'h1000,
    parameter int              NREGS    = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_adr_src,
    input  logic            i_mem_write,
    input  logic            i_mem_start,
    input  logic            i_IR_write,
    input  logic            i_reg_write,
    input  logic            i_PC_write,
    input  logic [1:0]      i_result_src,
    input  logic [1:0]      i_alu_src_a,
    input  logic [1:0]      i_alu_src_b,
    input  logic [2:0]      i_imm_src,
    input  logic [3:0]      i_alu_control,
    input  logic            i_md_start,
    output logic            o_bus_req,
    output logic            o_bus_we,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [XLEN-1:0] o_bus_wdata,
    output logic [2:0]      o_bus_funct3,
    input  logic            i_bus_ready,
    input  logic [XLEN-1:0] i_bus_rdata,
    output logic            o_mem_busy,
    output logic            o_mem_done,
    output logic            o_md_busy,
    output logic            o_md_done,
    output logic [6:0]      o_op_code,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_funct7,
    output logic            o_zero,
    output logic            o_alu_lsb
);
    localparam int RW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2;

    logic [XLEN-1:0] r_pc, r_old_pc, r_a, r_b, r_alu_out, r_data, r_addr, r_wdata;
    logic [XLEN-1:0] r_regs [NREGS];
    logic [31:0]     r_ir;
    logic [1:0]      r_state;
    logic            r_we, r_fetch;
    logic [XLEN-1:0] w_src_a, w_src_b, w_alu, w_imm, w_result, w_rs1, w_rs2, w_md_prod;
    logic [4:0]      w_rs1_idx, w_rs2_idx, w_rd_idx;
    logic            w_rd_ok, w_md_busy, w_md_fin, w_md_done;

    assign w_rs1_idx = r_ir[19:15];
    assign w_rs2_idx = r_ir[24:20];
    assign w_rd_idx  = r_ir[11:7];
    assign w_rs1 = (w_rs1_idx != 5'd0 && 32'(w_rs1_idx) < NREGS) ? r_regs[w_rs1_idx[RW-1:0]] : '0;
    assign w_rs2 = (w_rs2_idx != 5'd0 && 32'(w_rs2_idx) < NREGS) ? r_regs[w_rs2_idx[RW-1:0]] : '0;
    assign w_rd_ok = w_rd_idx != 5'd0 && 32'(w_rd_idx) < NREGS;

    assign w_src_a = i_alu_src_a == 2'd0 ? r_pc : i_alu_src_a == 2'd1 ? r_old_pc : i_alu_src_a == 2'd2 ? r_a : '0;
    assign w_src_b = i_alu_src_b == 2'd0 ? r_b : i_alu_src_b == 2'd1 ? w_imm : i_alu_src_b == 2'd2 ? XLEN'(4) : '0;
    assign w_result = i_result_src == 2'd0 ? r_alu_out : i_result_src == 2'd1 ? r_data :
                      i_result_src == 2'd2 ? r_pc + XLEN'(4) : r_old_pc + XLEN'(4);

    assign o_bus_req    = r_state == S_REQ;
    assign o_bus_we     = o_bus_req & r_we;
    assign o_bus_addr   = r_addr;
    assign o_bus_wdata  = r_wdata;
    assign o_bus_funct3 = r_ir[14:12];
    assign o_mem_busy   = r_state != S_IDLE;
    assign o_mem_done   = r_state == S_DONE;
    assign o_md_busy    = w_md_busy;
    assign o_md_done    = w_md_done;
    assign o_op_code    = r_ir[6:0];
    assign o_funct3     = r_ir[14:12];
    assign o_funct7     = r_ir[31:25];
    assign o_zero       = w_alu == '0;
    assign o_alu_lsb    = w_alu[0];

    // immediate decode: 0 I, 1 S, 2 B, 3 U, 4 J, sign-extended to XLEN
    always_comb begin
        case (i_imm_src)
            3'd0:    w_imm = XLEN'($signed(r_ir[31:20]));
            3'd1:    w_imm = XLEN'($signed({r_ir[31:25], r_ir[11:7]}));
            3'd2:    w_imm = XLEN'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));
            3'd3:    w_imm = XLEN'($signed({r_ir[31:12], 12'b0}));
            3'd4:    w_imm = XLEN'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0}));
            default: w_imm = '0;
        endcase
    end

    // ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass B
    always_comb begin
        case (i_alu_control)
            4'd0:    w_alu = w_src_a + w_src_b;
            4'd1:    w_alu = w_src_a - w_src_b;
            4'd2:    w_alu = w_src_a & w_src_b;
            4'd3:    w_alu = w_src_a | w_src_b;
            4'd4:    w_alu = w_src_a ^ w_src_b;
            4'd5:    w_alu = XLEN'($signed(w_src_a) < $signed(w_src_b));
            4'd6:    w_alu = XLEN'(w_src_a < w_src_b);
            4'd7:    w_alu = w_src_a << w_src_b[SW-1:0];
            4'd8:    w_alu = w_src_a >> w_src_b[SW-1:0];
            4'd9:    w_alu = $signed(w_src_a) >>> w_src_b[SW-1:0];
            4'd10:   w_alu = w_src_b;
            default: w_alu = '0;
        endcase
    end

    // bus sequencer: latch the request in IDLE, hold it until ready, pulse done
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_fetch  <= 1'b0;
            r_ir     <= '0;
            r_old_pc <= '0;
            r_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_mem_start) begin
                    r_addr  <= i_adr_src ? w_result : r_pc;
                    r_wdata <= r_b;
                    r_we    <= i_mem_write;
                    r_fetch <= i_IR_write;
                    r_state <= S_REQ;
                end
                S_REQ: if (i_bus_ready) begin
                    if (!r_we) r_data <= i_bus_rdata;
                    if (r_fetch) begin
                        r_ir     <= i_bus_rdata[31:0];
                        r_old_pc <= r_pc;
                    end
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // architectural state: PC and register file, written under controller command
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
            for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
        end else begin
            if (i_PC_write) r_pc <= w_result;
            if (i_reg_write && w_rd_ok) r_regs[w_rd_idx[RW-1:0]] <= w_result;
        end
    end

    // staging flops; ALU_out is frozen while the multiplier owns it
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
        end else begin
            r_a <= w_rs1;
            r_b <= w_rs2;
            if (w_md_fin) r_alu_out <= w_md_prod;
            else if (!w_md_busy) r_alu_out <= w_alu;
        end
    end

`ifdef MULDIV_EN
    localparam int CW = $clog2(XLEN + 1);
    logic [XLEN-1:0] r_md_a, r_md_b, r_md_acc;
    logic [CW-1:0]   r_md_cnt;
    logic            r_md_done;

    assign w_md_prod = r_md_acc + (r_md_b[0] ? r_md_a : '0);
    assign w_md_busy = r_md_cnt != '0;
    assign w_md_fin  = r_md_cnt == CW'(1);
    assign w_md_done = r_md_done;

    // shift-add multiplier: one multiplier bit per busy cycle, last step lands in ALU_out
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_md_a    <= '0;
            r_md_b    <= '0;
            r_md_acc  <= '0;
            r_md_cnt  <= '0;
            r_md_done <= 1'b0;
        end else begin
            r_md_done <= w_md_fin;
            if (!w_md_busy && i_md_start) begin
                r_md_a   <= r_a;
                r_md_b   <= r_b;
                r_md_acc <= '0;
                r_md_cnt <= CW'(XLEN);
            end else if (w_md_busy) begin
                r_md_acc <= w_md_prod;
                r_md_a   <= r_md_a << 1;
                r_md_b   <= r_md_b >> 1;
                r_md_cnt <= r_md_cnt - CW'(1);
            end
        end
    end
`else
    logic w_md_unused;
    assign w_md_unused = i_md_start;
    assign w_md_prod   = '0;
    assign w_md_busy   = 1'b0;
    assign w_md_fin    = 1'b0;
    assign w_md_done   = 1'b0;
`endif
endmodule

// File: tb/tb_mc_datapath_hs.sv
// tb_mc_datapath_hs: vector table, directed bus sequences and randomized ALU checks against an ISA-level model
module tb_mc_datapath_hs;
    logic clk = 1'b0, rst = 1'b1;
    logic adr_src = 0, mem_write = 0, mem_start = 0, ir_write = 0, reg_write = 0, pc_write = 0, md_start = 0, bus_ready = 0;
    logic [1:0] result_src = 0, src_a = 0, src_b = 0;
    logic [2:0] imm_src = 0;
    logic [3:0] alu_ctl = 0;
    logic [31:0] bus_rdata = 0;
    logic a_req, a_we, a_busy, a_done, a_mbusy, a_mdone, a_zero, a_lsb;
    logic [31:0] a_addr, a_wdata;
    logic [2:0] a_bf3, a_f3;
    logic [6:0] a_op, a_f7;
    logic b_unused_req, b_unused_we, b_unused_busy, b_unused_done, b_unused_mbusy, b_unused_mdone, b_unused_zero, b_unused_lsb;
    logic [31:0] b_addr, b_wdata;
    logic [2:0] b_unused_bf3, b_unused_f3;
    logic [6:0] b_unused_op, b_unused_f7;

    int errs = 0, checks = 0;
    logic [31:0] m_reg [32];
    logic [31:0] m_pc, m_opc, m_data;

    always #5 clk = ~clk;

    mc_datapath_hs dut (
        .i_clk(clk), .i_reset(rst), .i_adr_src(adr_src), .i_mem_write(mem_write), .i_mem_start(mem_start),
        .i_IR_write(ir_write), .i_reg_write(reg_write), .i_PC_write(pc_write), .i_result_src(result_src),
        .i_alu_src_a(src_a), .i_alu_src_b(src_b), .i_imm_src(imm_src), .i_alu_control(alu_ctl), .i_md_start(md_start),
        .o_bus_req(a_req), .o_bus_we(a_we), .o_bus_addr(a_addr), .o_bus_wdata(a_wdata), .o_bus_funct3(a_bf3),
        .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata), .o_mem_busy(a_busy), .o_mem_done(a_done),
        .o_md_busy(a_mbusy), .o_md_done(a_mdone), .o_op_code(a_op), .o_funct3(a_f3), .o_funct7(a_f7),
        .o_zero(a_zero), .o_alu_lsb(a_lsb));

    mc_datapath_hs #(.NREGS(16)) dut_e (
        .i_clk(clk), .i_reset(rst), .i_adr_src(adr_src), .i_mem_write(mem_write), .i_mem_start(mem_start),
        .i_IR_write(ir_write), .i_reg_write(reg_write), .i_PC_write(pc_write), .i_result_src(result_src),
        .i_alu_src_a(src_a), .i_alu_src_b(src_b), .i_imm_src(imm_src), .i_alu_control(alu_ctl), .i_md_start(md_start),
        .o_bus_req(b_unused_req), .o_bus_we(b_unused_we), .o_bus_addr(b_addr), .o_bus_wdata(b_wdata), .o_bus_funct3(b_unused_bf3),
        .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata), .o_mem_busy(b_unused_busy), .o_mem_done(b_unused_done),
        .o_md_busy(b_unused_mbusy), .o_md_done(b_unused_mdone), .o_op_code(b_unused_op), .o_funct3(b_unused_f3),
        .o_funct7(b_unused_f7), .o_zero(b_unused_zero), .o_alu_lsb(b_unused_lsb));

    typedef struct { logic [3:0] ctl; logic [31:0] a, b, y; } vec_t;
    vec_t vt [13];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd_ref(input logic [4:0] i, input int nr);
        return (i == 0 || int'(i) >= nr) ? 32'h0 : m_reg[i];
    endfunction

    function automatic logic [31:0] imm_ref(input logic [31:0] ir, input logic [2:0] sel);
        case (sel)
            3'd0: return {{20{ir[31]}}, ir[31:20]};
            3'd1: return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            3'd2: return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            3'd3: return {ir[31:12], 12'h000};
            3'd4: return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_alu(input logic [31:0] ir, input int nr);
        logic [31:0] x, y;
        int s;
        x = src_a == 0 ? m_pc : src_a == 1 ? m_opc : src_a == 2 ? rd_ref(ir[19:15], nr) : 32'h0;
        y = src_b == 0 ? rd_ref(ir[24:20], nr) : src_b == 1 ? imm_ref(ir, imm_src) : 32'd4;
        s = int'(y % 32);
        case (alu_ctl)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return {31'h0, $signed(x) < $signed(y)};
            4'd6: return {31'h0, x < y};
            4'd7: return x << s;
            4'd8: return x >> s;
            4'd9: return $signed(x) >>> s;
            4'd10: return y;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] st_ins(input int r);
        logic [4:0] f;
        f = r[4:0];
        return {7'h0, f, 5'h0, 3'b010, 5'h0, 7'h23};
    endfunction

    task automatic model_reset();
        m_pc = 32'h1000;
        m_opc = 0;
        m_data = 0;
        for (int i = 0; i < 32; i++) m_reg[i] = 0;
    endtask

    task automatic access(input bit we, input bit fetch, input bit asrc, input logic [31:0] rdata,
                          output logic [31:0] aa, output logic [31:0] wa, output logic [31:0] ab, output logic [31:0] wb);
        mem_write = we;
        ir_write = fetch;
        adr_src = asrc;
        mem_start = 1;
        tick();
        mem_start = 0;
        ir_write = 0;
        aa = a_addr;
        wa = a_wdata;
        ab = b_addr;
        wb = b_wdata;
        bus_ready = 1;
        bus_rdata = rdata;
        tick();
        bus_ready = 0;
        chk("mem_done", a_done, 1);
        tick();
        if (fetch) m_opc = m_pc;
        if (!we) m_data = rdata;
    endtask

    task automatic fetch(input logic [31:0] ins);
        logic [31:0] aa, wa, ab, wb;
        access(0, 1, 0, ins, aa, wa, ab, wb);
        chk("fetch_addr", aa, m_pc);
    endtask

    task automatic wreg(input int r, input logic [31:0] v);
        logic [31:0] aa, wa, ab, wb;
        logic [4:0] f;
        f = r[4:0];
        fetch({20'h0, f, 7'h13});
        access(0, 0, 0, v, aa, wa, ab, wb);
        result_src = 1;
        reg_write = 1;
        tick();
        reg_write = 0;
        if (r != 0) m_reg[r] = v;
    endtask

    task automatic peek(input logic [1:0] rs, output logic [31:0] aa, output logic [31:0] wa,
                        output logic [31:0] ab, output logic [31:0] wb);
        result_src = rs;
        tick();
        tick();
        access(1, 0, 1, 32'hA5A5A5A5, aa, wa, ab, wb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] aa, wa, ab, wb, w0, ins, ea;
        int n;
        vt[0]  = '{4'd0,  32'd5,          32'd7,          32'd12};
        vt[1]  = '{4'd0,  32'hFFFFFFFF,   32'd2,          32'd1};
        vt[2]  = '{4'd1,  32'd5,          32'd7,          32'hFFFFFFFE};
        vt[3]  = '{4'd1,  32'd9,          32'd9,          32'd0};
        vt[4]  = '{4'd2,  32'hF0F0,       32'hFF00,       32'hF000};
        vt[5]  = '{4'd3,  32'hF0F0,       32'hFF00,       32'hFFF0};
        vt[6]  = '{4'd4,  32'hF0F0,       32'hFF00,       32'h0FF0};
        vt[7]  = '{4'd5,  32'hFFFFFFFF,   32'd1,          32'd1};
        vt[8]  = '{4'd6,  32'hFFFFFFFF,   32'd1,          32'd0};
        vt[9]  = '{4'd7,  32'd1,          32'd33,         32'd2};
        vt[10] = '{4'd8,  32'h80000000,   32'd4,          32'h08000000};
        vt[11] = '{4'd9,  32'h80000000,   32'd4,          32'hF8000000};
        vt[12] = '{4'd10, 32'd3,          32'h1234,       32'h1234};
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 0;
        tick();
        chk("rst_bus_req", a_req, 0);
        chk("rst_mem_busy", a_busy, 0);
        chk("rst_mem_done", a_done, 0);
        chk("rst_md_busy", a_mbusy, 0);
        chk("rst_md_done", a_mdone, 0);
        chk("rst_op_code", a_op, 0);

        mem_write = 0;
        adr_src = 0;
        ir_write = 1;
        mem_start = 1;
        tick();
        mem_start = 0;
        ir_write = 0;
        chk("f0_req", a_req, 1);
        chk("f0_addr", a_addr, 32'h1000);
        chk("f0_done_early", a_done, 0);
        bus_ready = 1;
        bus_rdata = 32'h00500093;
        tick();
        bus_ready = 0;
        chk("f0_done", a_done, 1);
        chk("f0_req_drop", a_req, 0);
        chk("f0_ir_op", a_op, 7'h13);
        tick();
        chk("f0_done_pulse", a_done, 0);
        m_opc = m_pc;
        peek(3, aa, wa, ab, wb);
        chk("f0_old_pc4", aa, 32'h1004);

        foreach (vt[i]) begin end
        for (int k = 1; k < 32; k += 10) begin
            fetch(st_ins(k));
            peek(0, aa, wa, ab, wb);
            chk("rst_reg_zero", wa, 0);
            chk("rst_reg_zero_e", wb, 0);
        end

        ins = 32'h002081B3;
        ir_write = 1;
        mem_start = 1;
        tick();
        mem_start = 0;
        ir_write = 0;
        w0 = a_wdata;
        for (int i = 0; i < 6; i++) begin
            chk("ws_req", a_req, 1);
            chk("ws_addr", a_addr, m_pc);
            chk("ws_wdata", a_wdata, w0);
            chk("ws_ir_hold", a_op, m_reg[0] == 0 ? 32'h23 : 32'h0);
            chk("ws_no_done", a_done, 0);
            bus_ready = (i == 5);
            bus_rdata = ins;
            tick();
        end
        bus_ready = 0;
        chk("ws_done", a_done, 1);
        chk("ws_ir", a_op, 7'h33);
        m_opc = m_pc;
        tick();
        chk("ws_done_pulse", a_done, 0);

        wreg(2, 32'hDEADBEEF);
        fetch(st_ins(2));
        src_a = 3;
        src_b = 2;
        alu_ctl = 0;
        result_src = 0;
        tick();
        tick();
        mem_write = 1;
        adr_src = 1;
        mem_start = 1;
        tick();
        chk("st_req", a_req, 1);
        chk("st_we", a_we, 1);
        chk("st_addr", a_addr, 4);
        chk("st_wdata", a_wdata, 32'hDEADBEEF);
        chk("st_funct3", a_bf3, 2);
        tick();
        mem_start = 0;
        bus_ready = 1;
        bus_rdata = 32'h12345678;
        tick();
        bus_ready = 0;
        chk("st_done", a_done, 1);
        tick();
        chk("st_no_requeue_busy", a_busy, 0);
        chk("st_no_requeue_req", a_req, 0);
        peek(1, aa, wa, ab, wb);
        chk("st_rdata_discard", aa, m_data);

        foreach (vt[i]) begin
            wreg(1, vt[i].a);
            wreg(2, vt[i].b);
            fetch(32'h00208033);
            src_a = 2;
            src_b = 0;
            alu_ctl = vt[i].ctl;
            peek(0, aa, wa, ab, wb);
            chk($sformatf("vec%0d_alu", i), aa, vt[i].y);
            chk($sformatf("vec%0d_zero", i), a_zero, vt[i].y == 0);
            chk($sformatf("vec%0d_lsb", i), a_lsb, vt[i].y[0]);
        end

        result_src = 2;
        pc_write = 1;
        tick();
        pc_write = 0;
        m_pc = m_pc + 4;
        fetch(st_ins(0));

        wreg(17, 7);
        wreg(0, 32'h55);
        fetch(st_ins(17));
        peek(0, aa, wa, ab, wb);
        chk("x17_i", wa, 7);
        chk("x17_e", wb, 0);
        fetch(st_ins(0));
        peek(0, aa, wa, ab, wb);
        chk("x0_i", wa, 0);
        chk("x0_e", wb, 0);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                result_src = 2;
                pc_write = 1;
                tick();
                pc_write = 0;
                m_pc = m_pc + 4;
            end
            wreg($urandom_range(0, 31), $urandom);
            wreg($urandom_range(0, 31), $urandom);
            ins = $urandom;
            fetch(ins);
            src_a = 2'($urandom_range(0, 3));
            src_b = 2'($urandom_range(0, 2));
            imm_src = 3'($urandom_range(0, 4));
            alu_ctl = 4'($urandom_range(0, 10));
            peek(0, aa, wa, ab, wb);
            ea = exp_alu(ins, 32);
            chk("rnd_alu", aa, ea);
            chk("rnd_alu_e", ab, exp_alu(ins, 16));
            chk("rnd_rs2", wa, rd_ref(ins[24:20], 32));
            chk("rnd_rs2_e", wb, rd_ref(ins[24:20], 16));
            chk("rnd_zero", a_zero, ea == 0);
            chk("rnd_lsb", a_lsb, ea[0]);
            chk("rnd_f3", a_f3, ins[14:12]);
            chk("rnd_f7", a_f7, ins[31:25]);
        end

        ir_write = 1;
        mem_write = 0;
        adr_src = 0;
        mem_start = 1;
        tick();
        mem_start = 0;
        ir_write = 0;
        chk("rr_req", a_req, 1);
        #2 rst = 1;
        #1 chk("rr_req_async", a_req, 0);
        tick();
        #2 rst = 0;
        model_reset();
        bus_ready = 1;
        bus_rdata = 32'hFFFFFFFF;
        tick();
        bus_ready = 0;
        chk("rr_late_done", a_done, 0);
        chk("rr_late_busy", a_busy, 0);
        chk("rr_late_ir", a_op, 0);
        fetch(st_ins(5));
        peek(0, aa, wa, ab, wb);
        chk("rr_reg_clear", wa, 0);

`ifdef MULDIV_EN
        wreg(1, 7);
        wreg(2, 32'hFFFFFFFF);
        fetch(32'h00208033);
        src_a = 2;
        src_b = 0;
        alu_ctl = 0;
        result_src = 0;
        tick();
        tick();
        md_start = 1;
        tick();
        md_start = 0;
        n = 0;
        while (a_mbusy && n < 100) begin
            n++;
            tick();
        end
        chk("md_busy_cycles", n, 32);
        chk("md_done", a_mdone, 1);
        mem_write = 1;
        adr_src = 1;
        mem_start = 1;
        tick();
        mem_start = 0;
        chk("md_product", a_addr, 32'hFFFFFFF9);
        chk("md_done_pulse", a_mdone, 0);
        bus_ready = 1;
        tick();
        bus_ready = 0;
        tick();
`else
        md_start = 1;
        tick();
        md_start = 0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            chk("nomd_busy", a_mbusy, 0);
            chk("nomd_done", a_mdone, 0);
            tick();
        end
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
